instr_buffer: RTL and testbench

INSTR_BUFFER -- requirements
Module: instr_buffer

---
 rtl/instr_buffer.sv | 50 +++++
 tb/tb_instr_buffer.sv | 118 +++++++++++
 2 files changed

// File: rtl/instr_buffer.sv
// instr_buffer: circular instruction queue between fetch (up to 4 pushes/cycle) and decode (up to 2 pops/cycle).
// Push acceptance uses the pre-pop occupancy; there is no push-to-output bypass.
module instr_buffer #(
  parameter int IB_WIDTH_LOG2 = 4,
  parameter int DATA_WD       = 82
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_IB,
  input  logic [4*DATA_WD-1:0]       push_data,
  input  logic [2:0]                 push_num,
  output logic [IB_WIDTH_LOG2:0]     can_push_size,
  output logic [2*DATA_WD-1:0]       out_data,
  output logic [1:0]                 out_valid,
  input  logic [1:0]                 pop_num
);
  localparam int DEPTH = 1 << IB_WIDTH_LOG2;
  localparam int CW    = IB_WIDTH_LOG2 + 1;
  logic [DATA_WD-1:0]       mem_q [DEPTH];
  logic [IB_WIDTH_LOG2-1:0] head_q, head_d, tail_q, tail_d, head_nx;
  logic [CW-1:0]            count_q, count_d, pop_req, pop_eff, push_amt;
  logic [CW:0]              space_sum;
  logic                     push_ok;
  always_comb begin
    pop_req   = (pop_num == 2'd3) ? CW'(2) : CW'(pop_num);
    pop_eff   = (pop_req > count_q) ? count_q : pop_req;
    space_sum = (CW+1)'(count_q) + (CW+1)'(push_num);
    push_ok   = (push_num != 3'd0) && (push_num <= 3'd4) && (space_sum < (CW+1)'(DEPTH));
    push_amt  = push_ok ? CW'(push_num) : '0;
    count_d   = (rst || flush_IB) ? '0 : count_q + push_amt - pop_eff;
    head_d    = (rst || flush_IB) ? '0 : head_q + pop_eff[IB_WIDTH_LOG2-1:0];
    tail_d    = (rst || flush_IB) ? '0 : tail_q + push_amt[IB_WIDTH_LOG2-1:0];
    head_nx   = head_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
  end
  // Storage is not reset; a dropped or flushed push writes nothing.
  always_ff @(posedge clk) begin
    if (!rst && !flush_IB && push_ok)
      for (int j = 0; j < 4; j++)
        if (3'(j) < push_num)
          mem_q[tail_q + IB_WIDTH_LOG2'(j)] <= push_data[j*DATA_WD +: DATA_WD];
  end
  assign can_push_size = count_q;
  assign out_valid     = {count_q >= CW'(2), count_q != '0};
  assign out_data      = {mem_q[head_nx], mem_q[head_q]};
endmodule

// File: tb/tb_instr_buffer.sv
// tb_instr_buffer: directed + random stimulus checked every cycle against a queue model of the buffer.
module tb_instr_buffer;
  localparam int DW = 82;
  localparam int DEPTH = 16;
  logic clk = 0, rst, flush_IB;
  logic [4*DW-1:0] push_data;
  logic [2:0] push_num;
  logic [1:0] pop_num;
  logic [4:0] can_push_size;
  logic [2*DW-1:0] out_data;
  logic [1:0] out_valid;
  logic [DW-1:0] q[$];
  int n_cmp = 0, n_bad = 0;
  bit model_ok = 0;
  logic [DW-1:0] ea, eb, ec, w0, w1, w2, w3, ex;
  instr_buffer dut (.clk(clk), .rst(rst), .flush_IB(flush_IB), .push_data(push_data),
    .push_num(push_num), .can_push_size(can_push_size), .out_data(out_data),
    .out_valid(out_valid), .pop_num(pop_num));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic model_cmp();
    chk("count", 164'(can_push_size), 164'(q.size()));
    chk("valid", 164'(out_valid), 164'({q.size() >= 2, q.size() >= 1}));
    if (q.size() >= 1) chk("lane0", 164'(out_data[DW-1:0]), 164'(q[0]));
    if (q.size() >= 2) chk("lane1", 164'(out_data[2*DW-1:DW]), 164'(q[1]));
  endtask
  function automatic logic [DW-1:0] ent(input int k);
    return {k[17:0], 32'hC0DE0000 + k, 32'h12345678 ^ k};
  endfunction
  function automatic logic [4*DW-1:0] p4(input logic [DW-1:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction
  task automatic cycle(input logic r, f, input logic [2:0] pn, input logic [1:0] pp, input logic [4*DW-1:0] pd);
    int pe;
    bit acc;
    rst = r; flush_IB = f; push_num = pn; pop_num = pp; push_data = pd;
    #1;
    if (model_ok) model_cmp();
    pe = (pp == 2'd3) ? 2 : int'(pp);
    if (pe > q.size()) pe = q.size();
    acc = (pn >= 1) && (pn <= 4) && (q.size() + int'(pn) < DEPTH);
    if (r || f) q.delete();
    else begin
      repeat (pe) void'(q.pop_front());
      if (acc) for (int j = 0; j < int'(pn); j++) q.push_back(pd[j*DW +: DW]);
    end
    if (r) model_ok = 1;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic fill(input int n);
    while (n > 0) begin
      cycle(0, 0, 3'((n > 4) ? 4 : n), 0, p4(ent(n), ent(n+100), ent(n+200), ent(n+300)));
      n -= 4;
    end
  endtask
  initial begin
    logic [4*DW-1:0] rd;
    ea = ent(1); eb = ent(2); ec = ent(3);
    w0 = ent(40); w1 = ent(41); w2 = ent(42); w3 = ent(43); ex = ent(99);
    rst = 1; flush_IB = 0; push_num = 0; pop_num = 0; push_data = '0;
    @(negedge clk);
    cycle(1, 0, 0, 0, '0);
    chk("rst_count", 164'(can_push_size), 164'(0));
    chk("rst_valid", 164'(out_valid), 164'(0));
    rst = 0; push_num = 3; push_data = p4(ea, eb, ec, '0); #1;
    chk("nobypass_valid", 164'(out_valid), 164'(0));
    cycle(0, 0, 3, 0, p4(ea, eb, ec, '0));
    chk("abc_count", 164'(can_push_size), 164'(3));
    chk("abc_valid", 164'(out_valid), 164'(3));
    chk("abc_data", out_data, {eb, ea});
    cycle(1, 0, 0, 0, '0);
    fill(13);
    chk("fill13", 164'(can_push_size), 164'(13));
    cycle(0, 0, 3, 0, p4(ex, ex, ex, ex));
    chk("drop13p3", 164'(can_push_size), 164'(13));
    cycle(0, 0, 2, 0, p4(ex, ex, ex, ex));
    chk("acc13p2", 164'(can_push_size), 164'(15));
    cycle(0, 0, 1, 2, p4(ex, ex, ex, ex));
    chk("full_pop_drop", 164'(can_push_size), 164'(13));
    repeat (6) cycle(0, 0, 0, 2, '0);
    chk("cnt1", 164'(can_push_size), 164'(1));
    cycle(0, 0, 0, 2, '0);
    chk("pop_under", 164'(can_push_size), 164'(0));
    chk("pop_under_v", 164'(out_valid), 164'(0));
    cycle(1, 0, 0, 0, '0);
    fill(14);
    repeat (7) cycle(0, 0, 0, 2, '0);
    cycle(0, 0, 4, 0, p4(w0, w1, w2, w3));
    chk("wrap_a", out_data, {w1, w0});
    cycle(0, 0, 0, 2, '0);
    chk("wrap_b", out_data, {w3, w2});
    cycle(0, 0, 1, 3, p4(ex, '0, '0, '0));
    chk("wrap_tail", 164'(out_data[DW-1:0]), 164'(ex));
    cycle(1, 0, 0, 0, '0);
    fill(9);
    cycle(0, 1, 4, 0, p4(ea, eb, ec, ex));
    chk("flush_cnt", 164'(can_push_size), 164'(0));
    chk("flush_v", 164'(out_valid), 164'(0));
    cycle(0, 0, 1, 0, p4(ex, '0, '0, '0));
    chk("flush_x", 164'(out_data[DW-1:0]), 164'(ex));
    for (int i = 0; i < 4000; i++) begin
      for (int j = 0; j < 4; j++) rd[j*DW +: DW] = DW'({$urandom, $urandom, $urandom});
      cycle($urandom_range(0, 299) == 0, $urandom_range(0, 59) == 0,
            ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4)),
            2'($urandom_range(0, 3)), rd);
    end
    model_cmp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
